// File: rtl/regfile_scoreboard.sv
// Integer register file with an integrated dispatch/writeback scoreboard.
// Combinational read ports with same-cycle writeback bypass, a pending bit
// per architectural register, per-port hazard flags and an aggregate issue_ok.
// Register 0 is hardwired to zero and can never become pending.
module regfile_scoreboard #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int NWR  = 1,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NWR-1:0]      wr_valid,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic [NRD-1:0]      rd_valid,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_hazard,
    output logic                issue_ok,
    input  logic                alloc_valid,
    input  logic [AW-1:0]       alloc_addr,
    input  logic                flush,
    output logic [AW:0]         pending_cnt
);

    localparam int CW = AW + 1;

    // Architectural state
    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] pending;

    // Unpacked views of the flat port vectors
    logic [AW-1:0]   wa  [NWR];
    logic [XLEN-1:0] wd  [NWR];
    logic [NWR-1:0]  wen;
    logic [AW-1:0]   ra  [NRD];

    // Per-read-port intermediate results
    logic [XLEN-1:0] rd_word [NRD];
    logic [NRD-1:0]  rd_hit;

    // Next-state scoreboard and its population count
    logic [NREG-1:0] pending_nxt;
    logic [CW-1:0]   cnt_nxt;

    // Split flat port vectors into per-port fields; writes to x0 are dropped here
    always_comb begin
        wen = '0;
        for (int i = 0; i < NWR; i++) begin
            wa[i]  = wr_addr[i*AW +: AW];
            wd[i]  = wr_data[i*XLEN +: XLEN];
            wen[i] = wr_valid[i] && (wa[i] != '0);
        end
        for (int j = 0; j < NRD; j++) begin
            ra[j] = rd_addr[j*AW +: AW];
        end
    end

    // Read ports: stored value, overridden by the highest-index matching writeback
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it
        // unassigned; a missing default here is what turns into an inferred latch.
        rd_data   = '0;
        rd_hazard = '0;
        rd_hit    = '0;
        for (int j = 0; j < NRD; j++) begin
            rd_word[j] = regs[ra[j]];
            for (int i = 0; i < NWR; i++) begin
                if (wen[i] && (wa[i] == ra[j])) begin
                    rd_word[j] = wd[i];
                    rd_hit[j]  = 1'b1;
                end
            end
            if ((ra[j] == '0) || !rd_valid[j]) begin
                rd_word[j] = '0;
            end
            rd_hazard[j] = rd_valid[j] & pending[ra[j]] & ~rd_hit[j];
            rd_data[j*XLEN +: XLEN] = rd_word[j];
        end
    end

    // Any hazard on a requested operand blocks issue
    assign issue_ok = ~|rd_hazard;

    // Scoreboard next state: flush beats everything, a new alloc beats a writeback clear
    always_comb begin
        pending_nxt = pending;
        if (flush) begin
            pending_nxt = '0;
        end else begin
            for (int i = 0; i < NWR; i++) begin
                if (wen[i]) begin
                    pending_nxt[wa[i]] = 1'b0;
                end
            end
            if (alloc_valid && (alloc_addr != '0)) begin
                pending_nxt[alloc_addr] = 1'b1;
            end
        end
        pending_nxt[0] = 1'b0;

        cnt_nxt = '0;
        for (int k = 0; k < NREG; k++) begin
            cnt_nxt = cnt_nxt + CW'(pending_nxt[k]);
        end
    end

    // All state: register contents, pending bits and the registered pending count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the register array is reset explicitly because reads must return
            // zero straight out of reset; this costs a reset net on every storage bit.
            for (int k = 0; k < NREG; k++) begin
                regs[k] <= '0;
            end
            pending     <= '0;
            pending_cnt <= '0;
        end else begin
            // NOTE: non-blocking writes in port order make the highest port win on a
            // same-address collision, matching the bypass priority on the read side.
            for (int i = 0; i < NWR; i++) begin
                if (wen[i]) begin
                    regs[wa[i]] <= wd[i];
                end
            end
            pending     <= pending_nxt;
            pending_cnt <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard (two read ports, two write ports).
// Expectations are queued as stimulus is applied and compared when the
// combinational outputs have settled, mid-cycle, away from the clock edge.
module tb_regfile_scoreboard;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int AW   = 5;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NWR-1:0]      wr_valid;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic [NRD-1:0]      rd_valid;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_hazard;
    logic                issue_ok;
    logic                alloc_valid;
    logic [AW-1:0]       alloc_addr;
    logic                flush;
    logic [AW:0]         pending_cnt;

    regfile_scoreboard #(
        .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_hazard(rd_hazard), .issue_ok(issue_ok),
        .alloc_valid(alloc_valid), .alloc_addr(alloc_addr),
        .flush(flush), .pending_cnt(pending_cnt)
    );

    always #5 clk = ~clk;

    typedef enum int {K_D0, K_D1, K_HZ, K_OK, K_CNT} kind_e;
    typedef struct {
        string       tag;
        kind_e       kind;
        logic [31:0] val;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] model [NREG];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    endtask

    function automatic logic [31:0] observe(input kind_e k);
        case (k)
            K_D0:    return rd_data[31:0];
            K_D1:    return rd_data[63:32];
            K_HZ:    return {30'b0, rd_hazard};
            K_OK:    return {31'b0, issue_ok};
            default: return {26'b0, pending_cnt};
        endcase
    endfunction

    task automatic expect_val(input string tag, input kind_e k, input logic [31:0] v);
        exp_t e;
        e.tag = tag; e.kind = k; e.val = v;
        sb_q.push_back(e);
    endtask

    // Let combinational outputs settle, then pop and compare everything queued
    task automatic compare_all();
        exp_t e;
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.tag, observe(e.kind), e.val);
        end
    endtask

    task automatic idle();
        wr_valid = '0; wr_addr = '0; wr_data = '0;
        rd_valid = '0; rd_addr = '0;
        alloc_valid = 1'b0; alloc_addr = '0; flush = 1'b0;
    endtask

    task automatic rd(input int p, input logic [AW-1:0] a);
        rd_valid[p] = 1'b1;
        rd_addr[p*AW +: AW] = a;
    endtask

    task automatic wr(input int p, input logic [AW-1:0] a, input logic [31:0] d);
        wr_valid[p] = 1'b1;
        wr_addr[p*AW +: AW] = a;
        wr_data[p*XLEN +: XLEN] = d;
    endtask

    task automatic alloc(input logic [AW-1:0] a);
        alloc_valid = 1'b1;
        alloc_addr  = a;
    endtask

    // Compare this cycle's expectations, then advance past the next rising edge
    task automatic step();
        compare_all();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();

        // Reset: reads of x5 and x0 return zero, no hazard
        rd(0, 5); rd(1, 0);
        #2;
        expect_val("rst_d0", K_D0, 32'h0);
        expect_val("rst_d1", K_D1, 32'h0);
        expect_val("rst_hz", K_HZ, 32'h0);
        expect_val("rst_ok", K_OK, 32'h1);
        expect_val("rst_cnt", K_CNT, 32'h0);
        compare_all();
        #5 rst_n = 1'b1;
        @(posedge clk); #1; idle();

        // Write x3 (bypass visible same cycle), write x0 (ignored)
        wr(0, 3, 32'hDEADBEEF); rd(0, 3);
        wr(1, 0, 32'h1234);     rd(1, 0);
        expect_val("x3_bypass", K_D0, 32'hDEADBEEF);
        expect_val("x0_bypass", K_D1, 32'h0);
        step();
        rd(0, 3); rd(1, 0);
        expect_val("x3_stored", K_D0, 32'hDEADBEEF);
        expect_val("x0_stored", K_D1, 32'h0);
        step();
        rd(0, 3); rd_addr[AW +: AW] = 5'd3;
        expect_val("rd_invalid_zero", K_D1, 32'h0);
        step();

        // Alloc x7, then hazard, then writeback bypass clears it
        alloc(7);
        expect_val("alloc_cnt_pre", K_CNT, 32'h0);
        step();
        rd(1, 7);
        expect_val("x7_hz", K_HZ, 32'h2);
        expect_val("x7_ok", K_OK, 32'h0);
        expect_val("x7_cnt", K_CNT, 32'h1);
        compare_all();
        wr(0, 7, 32'h55);
        expect_val("x7_wb_data", K_D1, 32'h55);
        expect_val("x7_wb_hz", K_HZ, 32'h0);
        expect_val("x7_wb_ok", K_OK, 32'h1);
        step();
        rd(1, 7);
        expect_val("x7_cnt_after", K_CNT, 32'h0);
        expect_val("x7_data_after", K_D1, 32'h55);
        step();

        // Alloc and writeback x9 in the same cycle: data written, still pending
        alloc(9); wr(0, 9, 32'hA5);
        step();
        rd(0, 9);
        expect_val("x9_data", K_D0, 32'hA5);
        expect_val("x9_hz", K_HZ, 32'h1);
        expect_val("x9_ok", K_OK, 32'h0);
        expect_val("x9_cnt", K_CNT, 32'h1);
        step();
        wr(0, 9, 32'hA5);
        step();
        expect_val("x9_cleared_cnt", K_CNT, 32'h0);
        compare_all();

        // Alloc x1, x2, x4, re-alloc x1; then flush with a competing alloc
        alloc(1); step();
        alloc(2); step();
        alloc(4); step();
        alloc(1);
        expect_val("cnt_three", K_CNT, 32'h3);
        step();
        expect_val("realloc_cnt", K_CNT, 32'h3);
        flush = 1'b1; alloc(6); wr(0, 5, 32'h77);
        rd(0, 1); rd(1, 2);
        expect_val("preflush_hz", K_HZ, 32'h3);
        step();
        rd(0, 1); rd(1, 2);
        expect_val("flush_cnt", K_CNT, 32'h0);
        expect_val("flush_hz12", K_HZ, 32'h0);
        expect_val("flush_ok", K_OK, 32'h1);
        step();
        rd(0, 4); rd(1, 6);
        expect_val("flush_hz46", K_HZ, 32'h0);
        step();
        rd(0, 5);
        expect_val("flush_write_kept", K_D0, 32'h77);
        step();

        // Two write ports hit x10: port 1 wins bypass and storage
        wr(0, 10, 32'h1); wr(1, 10, 32'h2); rd(0, 10);
        expect_val("dual_bypass", K_D0, 32'h2);
        step();
        rd(0, 10);
        expect_val("dual_stored", K_D0, 32'h2);
        step();

        // Random writes across both ports, checked against a value model
        for (int k = 0; k < 8; k++) begin
            model[16+k] = $urandom;
            wr(k % 2, AW'(16 + k), model[16+k]);
            step();
        end
        for (int k = 0; k < 8; k++) begin
            rd(0, AW'(16 + k)); rd(1, AW'(23 - k));
            expect_val($sformatf("rand_d0_x%0d", 16 + k), K_D0, model[16+k]);
            expect_val($sformatf("rand_d1_x%0d", 23 - k), K_D1, model[23-k]);
            step();
        end

        // Asynchronous reset mid-cycle
        alloc(12); step();
        rd(0, 10); rd(1, 12);
        expect_val("pre_rst_d0", K_D0, 32'h2);
        expect_val("pre_rst_hz", K_HZ, 32'h2);
        expect_val("pre_rst_cnt", K_CNT, 32'h1);
        compare_all();
        rst_n = 1'b0;
        expect_val("async_rst_d0", K_D0, 32'h0);
        expect_val("async_rst_hz", K_HZ, 32'h0);
        expect_val("async_rst_ok", K_OK, 32'h1);
        expect_val("async_rst_cnt", K_CNT, 32'h0);
        compare_all();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised integer register file with an integrated scoreboard, sitting between decode/dispatch and writeback. It provides NRD combinational read ports with same-cycle writeback bypass and NWR write ports. A per-register pending bit is set at dispatch and cleared at writeback. A per-port hazard flag plus an aggregate issue_ok replace the single stall bit of the previous generation. Flush clears all pending state deterministically.

Parameters:
XLEN, 32, data width of each register
NREG, 32, number of architectural registers (power of 2, >=2); register 0 hardwired to zero
NRD, 2, number of read ports
NWR, 1, number of write ports
AW, $clog2(NREG), address width (derived, not overridable)

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
wr_valid  in  NWR  per-port write enable
wr_addr  in  NWR*AW  per-port write address
wr_data  in  NWR*XLEN  per-port write data
rd_valid  in  NRD  per-port read request (operand used)
rd_addr  in  NRD*AW  per-port read address
rd_data  out  NRD*XLEN  per-port read data
rd_hazard  out  NRD  per-port: operand pending and not bypassed this cycle
issue_ok  out  1  no valid read port has a hazard
alloc_valid  in  1  dispatch reserves a destination this cycle
alloc_addr  in  AW  destination register to mark pending
flush  in  1  pipeline flush; clear all pending bits
pending_cnt  out  $clog2(NREG)+1  number of registers currently pending

Behaviour:
- Reset (rst_n=0, async): all registers=0, all pending=0, pending_cnt=0. Outputs are then combinational from state: rd_data=0, rd_hazard=0, issue_ok=1.
- Register 0: writes ignored, never set pending, always reads 0, rd_hazard always 0.
- Write: on clk rise, for each wr_valid[i] with wr_addr[i]!=0, reg[wr_addr[i]]<=wr_data[i] and pending[wr_addr[i]]<=0.
  - Two write ports, same address, same cycle: the highest port index wins the data.
- Read (0 latency, combinational):
  - rd_data[j] = bypassed data if any wr_valid[i] hits rd_addr[j] (!=0) this cycle, highest i wins; else reg[rd_addr[j]].
  - rd_data[j] is a don't-care when rd_valid[j]=0; output 0 in that case.
- Hazard: rd_hazard[j] = rd_valid[j] & pending[rd_addr[j]] & ~(write to rd_addr[j] this cycle).
- issue_ok = ~|rd_hazard.
- Alloc: on clk rise, if alloc_valid & alloc_addr!=0 & ~flush, then pending[alloc_addr]<=1.
  - Alloc and writeback to the same address in the same cycle: alloc wins, pending stays 1 (new producer). Data is still written.
  - Alloc to an already-pending register: stays 1; no counter change.
- Flush: on clk rise, all pending<=0 and alloc is ignored. Writes in the same cycle still update data.
- pending_cnt: registered population count of pending bits, updated on the same edge; range 0..NREG-1.
- No latches. All state is in one always_ff with async reset; read/bypass/hazard logic is in always_comb.
- Reset asserted mid-operation clears state immediately, regardless of clk.

Test Plan:
- Reset, then read x5 and x0 on both ports -> rd_data=0, rd_hazard=0, issue_ok=1, pending_cnt=0.
- Write x3=0xDEADBEEF, next cycle read x3 -> 0xDEADBEEF. Write x0=0x1234, read x0 -> 0.
- Alloc x7; next cycle read x7 on port1 -> rd_hazard[1]=1, issue_ok=0, pending_cnt=1. Writeback x7=0x55 in that same cycle -> rd_data[1]=0x55, rd_hazard[1]=0, issue_ok=1. Following cycle -> pending_cnt=0.
- Same-cycle alloc x9 and writeback x9=0xA5 -> next cycle x9 reads 0xA5, still pending, rd_hazard=1.
- Alloc x1, x2, x4 on successive cycles -> pending_cnt=3. Assert flush together with alloc x6 -> next cycle pending_cnt=0, no hazard on x1, x2, x4, x6.
- NWR=2 build: both ports write x10 (0x1 on port0, 0x2 on port1) -> bypass and stored value are both 0x2. Assert rst_n low between clock edges -> outputs return to reset values immediately.
